// File: rtl/debug_display_mux_pkg.sv
// Shared constants and helpers for the debug display controller.
package display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Ceiling log2; clog2(0) = clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Number of pages needed to show nch channels on ndig digits.
    function automatic int unsigned page_count(input int unsigned nch,
                                               input int unsigned data_w,
                                               input int unsigned ndig);
        int unsigned cpp;
        cpp = ndig / (data_w / 4);
        return (nch + cpp - 1) / cpp;
    endfunction

    // Width of the page index, never narrower than one bit.
    function automatic int unsigned page_width(input int unsigned nch,
                                               input int unsigned data_w,
                                               input int unsigned ndig);
        int unsigned w;
        w = clog2(page_count(nch, data_w, ndig));
        return (w == 0) ? 1 : w;
    endfunction

    // Hex digit to active-low segments, bit0 = a .. bit6 = g.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/debug_display_mux_if.sv
// Channel inputs, paging controls and display outputs of the debug display.
interface debug_display_mux_if #(
    parameter int unsigned NCH    = 8,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NDIG   = 8,
    parameter int unsigned DIV_W  = 26
);
    localparam int unsigned PAGE_W = display_pkg::page_width(NCH, DATA_W, NDIG);

    logic [NCH*DATA_W-1:0] ch_data;
    logic                  key_next;
    logic                  auto_mode;
    logic [DIV_W-1:0]      scroll_div;
    logic                  freeze;
    logic [NDIG*7-1:0]     hex;
    logic [PAGE_W-1:0]     page;
    logic                  frozen;

    modport master (
        output ch_data, key_next, auto_mode, scroll_div, freeze,
        input  hex, page, frozen
    );

    modport slave (
        input  ch_data, key_next, auto_mode, scroll_div, freeze,
        output hex, page, frozen
    );

endinterface

// File: rtl/debug_display_mux_hex7seg.sv
// Combinational 4-bit to active-low seven-segment decoder.
module hex7seg
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup only; blanking is decided by the parent.
    always_comb seg = hex_to_seg(nibble);

endmodule

// File: rtl/debug_display_mux.sv
// Paged hex display of NCH channel words with debounced manual paging,
// auto-scroll prescaler and freeze snapshot.
module debug_display_mux
    import display_pkg::*;
#(
    parameter int unsigned NCH     = 8,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned NDIG    = 8,
    parameter int unsigned DIV_W   = 26,
    parameter int unsigned DEB_CYC = 16
) (
    input  logic               Clock,
    input  logic               Resetn,
    debug_display_mux_if.slave dbg
);

    localparam int unsigned CD     = DATA_W / 4;
    localparam int unsigned CPP    = NDIG / CD;
    localparam int unsigned NPAGE  = page_count(NCH, DATA_W, NDIG);
    localparam int unsigned PAGE_W = page_width(NCH, DATA_W, NDIG);
    localparam int unsigned SLOTS  = NPAGE * CPP;
    localparam int unsigned DEB_W  = clog2(DEB_CYC + 1);

    logic [PAGE_W-1:0]       page_q;
    logic [DIV_W-1:0]        pre_q;
    logic [DEB_W-1:0]        deb_q;
    logic                    armed_q;
    logic                    mode_q;
    logic [NCH*DATA_W-1:0]   snap_q;
    logic                    frozen_q;
    logic [NDIG*7-1:0]       hex_q;

    logic                    step;
    logic                    tick;
    logic                    auto_on;
    logic                    mode_chg;

    logic [NCH*DATA_W-1:0]   src;
    logic [SLOTS*DATA_W-1:0] src_pad;
    logic [NDIG*4-1:0]       nib;
    logic [NDIG-1:0]         blank;
    logic [NDIG*7-1:0]       seg;
    logic [NDIG*7-1:0]       hex_next;

    // Step fires on the edge that brings the counter to DEB_CYC, so a key
    // held for exactly DEB_CYC cycles is accepted.
    always_comb begin
        step     = dbg.key_next && armed_q && (deb_q == DEB_W'(DEB_CYC - 1));
        auto_on  = dbg.auto_mode && (dbg.scroll_div != '0);
        mode_chg = (dbg.auto_mode != mode_q);
        tick     = auto_on && !mode_chg && (pre_q >= dbg.scroll_div - 1'b1);
    end

    // Key debounce counter with one-shot arming.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            deb_q   <= '0;
            armed_q <= 1'b1;
        end else if (!dbg.key_next) begin
            deb_q   <= '0;
            armed_q <= 1'b1;
        end else begin
            if (deb_q != DEB_W'(DEB_CYC)) deb_q <= deb_q + 1'b1;
            if (step) armed_q <= 1'b0;
        end
    end

    // Auto-scroll prescaler; held at 0 when inactive or on a mode change.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            pre_q  <= '0;
            mode_q <= 1'b0;
        end else begin
            mode_q <= dbg.auto_mode;
            if (mode_chg || !auto_on || tick) pre_q <= '0;
            else                              pre_q <= pre_q + 1'b1;
        end
    end

    // Page index; coincident step and tick advance once.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            page_q <= '0;
        end else if (step || tick) begin
            page_q <= (page_q == PAGE_W'(NPAGE - 1)) ? '0 : page_q + 1'b1;
        end
    end

    // Snapshot capture on the rising edge of freeze.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            snap_q   <= '0;
            frozen_q <= 1'b0;
        end else begin
            frozen_q <= dbg.freeze;
            if (dbg.freeze && !frozen_q) snap_q <= dbg.ch_data;
        end
    end

    // Select source and per-digit nibble; on the capture cycle live data
    // equals the value being captured, so live is used until frozen is set.
    always_comb begin
        int unsigned c;
        src     = (dbg.freeze && frozen_q) ? snap_q : dbg.ch_data;
        src_pad = '0;
        src_pad[NCH*DATA_W-1:0] = src;
        nib   = '0;
        blank = '0;
        for (int unsigned d = 0; d < NDIG; d++) begin
            c = 32'(page_q) * CPP + d / CD;
            blank[d] = (c >= NCH);
            nib[d*4 +: 4] = src_pad[(c * DATA_W + (d % CD) * 4) +: 4];
        end
    end

    for (genvar d = 0; d < NDIG; d++) begin : g_dig
        hex7seg u_dec (
            .nibble (nib[d*4 +: 4]),
            .seg    (seg[d*7 +: 7])
        );
        assign hex_next[d*7 +: 7] = blank[d] ? SEG_BLANK : seg[d*7 +: 7];
    end

    // Registered segment outputs, blank during reset.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) hex_q <= '1;
        else         hex_q <= hex_next;
    end

    assign dbg.hex    = hex_q;
    assign dbg.page   = page_q;
    assign dbg.frozen = frozen_q;

endmodule

// File: tb/tb_debug_display_mux.sv
// Scoreboard bench for debug_display_mux (NCH=5, 16-bit channels, 8 digits).
module tb_debug_display_mux;
    import display_pkg::*;

    localparam int unsigned NCH     = 5;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned NDIG    = 8;
    localparam int unsigned DIV_W   = 26;
    localparam int unsigned DEB_CYC = 16;
    localparam logic [63:0] ALL_BLANK = 64'({NDIG*7{1'b1}});

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    debug_display_mux_if #(.NCH(NCH), .DATA_W(DATA_W), .NDIG(NDIG), .DIV_W(DIV_W)) dbg ();

    debug_display_mux #(
        .NCH(NCH), .DATA_W(DATA_W), .NDIG(NDIG), .DIV_W(DIV_W), .DEB_CYC(DEB_CYC)
    ) dut (
        .Clock  (clk),
        .Resetn (rst_n),
        .dbg    (dbg)
    );

    typedef struct {
        string       tag;
        int          kind;   // 0 page, 1 hex, 2 frozen
        logic [63:0] val;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [15:0] chans [NCH];
    logic [15:0] snap  [NCH];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input int kind, input logic [63:0] val);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [63:0] got;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                0:       got = 64'(dbg.page);
                1:       got = 64'(dbg.hex);
                default: got = 64'(dbg.frozen);
            endcase
            check(e.tag, got, e.val);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_ch();
        for (int k = 0; k < NCH; k++) dbg.ch_data[k*16 +: 16] = chans[k];
    endtask

    task automatic take_snap();
        for (int k = 0; k < NCH; k++) snap[k] = chans[k];
    endtask

    task automatic press();
        dbg.key_next = 1'b1;
        cyc(16);
        dbg.key_next = 1'b0;
        cyc(1);
    endtask

    // Two channels of four digits per page; channels past NCH are blank.
    function automatic logic [63:0] exp_hex(input int unsigned pg, input bit use_snap);
        logic [NDIG*7-1:0] h;
        logic [15:0]       w;
        logic [2:0]        ci;
        int unsigned       c;
        h = '1;
        for (int d = 0; d < NDIG; d++) begin
            c = pg * 2 + d / 4;
            if (c < NCH) begin
                ci = 3'(c);
                w  = use_snap ? snap[ci] : chans[ci];
                h[d*7 +: 7] = seg_tab[w[(d % 4) * 4 +: 4]];
            end
        end
        return 64'(h);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n          = 1'b0;
        dbg.key_next   = 1'b0;
        dbg.auto_mode  = 1'b0;
        dbg.scroll_div = '0;
        dbg.freeze     = 1'b0;
        chans = '{16'h1234, 16'hABCD, 16'h5678, 16'h9EF0, 16'h4321};
        apply_ch();

        cyc(2);
        push("rst_page", 0, 64'd0);
        push("rst_hex", 1, ALL_BLANK);
        push("rst_frozen", 2, 64'd0);
        drain();

        @(negedge clk);
        rst_n = 1'b1;
        cyc(1);
        push("p0_page", 0, 64'd0);
        push("p0_hex", 1, 64'({7'h08, 7'h03, 7'h46, 7'h21, 7'h79, 7'h24, 7'h30, 7'h19}));
        push("p0_frozen", 2, 64'd0);
        drain();

        dbg.key_next = 1'b1;
        cyc(15);
        push("deb_15", 0, 64'd0);
        drain();
        cyc(1);
        push("deb_16", 0, 64'd1);
        drain();
        cyc(24);
        push("deb_held", 0, 64'd1);
        push("p1_hex", 1, exp_hex(1, 0));
        drain();

        dbg.key_next = 1'b0;
        cyc(1);
        dbg.key_next = 1'b1;
        cyc(16);
        dbg.key_next = 1'b0;
        push("repress_page", 0, 64'd2);
        drain();
        cyc(1);
        push("p2_hex", 1, 64'({{4{7'h7F}}, 7'h19, 7'h30, 7'h24, 7'h79}));
        drain();

        press();
        push("wrap_page", 0, 64'd0);
        drain();
        dbg.key_next = 1'b1;
        cyc(10);
        dbg.key_next = 1'b0;
        cyc(20);
        push("glitch_page", 0, 64'd0);
        drain();

        dbg.auto_mode  = 1'b1;
        dbg.scroll_div = DIV_W'(5);
        cyc(5);
        push("auto_pre", 0, 64'd0);
        drain();
        cyc(1);
        push("auto_t1", 0, 64'd1);
        drain();
        cyc(5);
        push("auto_t2", 0, 64'd2);
        drain();
        cyc(5);
        push("auto_t3", 0, 64'd0);
        drain();

        cyc(4);
        dbg.key_next = 1'b1;
        cyc(15);
        push("coinc_pre", 0, 64'd0);
        drain();
        cyc(1);
        push("coinc_once", 0, 64'd1);
        drain();
        dbg.key_next   = 1'b0;
        dbg.scroll_div = '0;
        cyc(20);
        push("div0_page", 0, 64'd1);
        drain();
        dbg.auto_mode = 1'b0;
        cyc(1);

        press();
        press();
        push("frz_start_page", 0, 64'd0);
        drain();
        chans[0] = 16'h0042;
        apply_ch();
        cyc(1);
        push("live_0042", 1, exp_hex(0, 0));
        drain();
        dbg.freeze = 1'b1;
        take_snap();
        cyc(1);
        push("frz_frozen", 2, 64'd1);
        drain();
        chans[0] = 16'hFFFF;
        chans[2] = 16'h0000;
        apply_ch();
        cyc(1);
        push("frz_hold", 1, exp_hex(0, 1));
        drain();
        cyc(3);
        push("frz_hold_later", 1, exp_hex(0, 1));
        push("frz_still", 2, 64'd1);
        drain();
        press();
        push("frz_page1", 0, 64'd1);
        push("frz_page1_hex", 1, exp_hex(1, 1));
        drain();
        press();
        press();
        dbg.freeze = 1'b0;
        cyc(1);
        push("unfrz_frozen", 2, 64'd0);
        push("unfrz_hex", 1, exp_hex(0, 0));
        drain();

        dbg.auto_mode  = 1'b1;
        dbg.scroll_div = DIV_W'(5);
        dbg.freeze     = 1'b1;
        take_snap();
        cyc(11);
        push("pre_rst_page", 0, 64'd2);
        push("pre_rst_frozen", 2, 64'd1);
        drain();
        chans[4] = 16'hBEEF;
        apply_ch();
        cyc(1);
        push("pre_rst_hex", 1, exp_hex(2, 1));
        drain();
        #3;
        rst_n = 1'b0;
        #1;
        push("arst_page", 0, 64'd0);
        push("arst_frozen", 2, 64'd0);
        push("arst_hex", 1, ALL_BLANK);
        drain();
        cyc(2);
        push("arst_hold_page", 0, 64'd0);
        push("arst_hold_hex", 1, ALL_BLANK);
        drain();
        @(negedge clk);
        rst_n = 1'b1;
        take_snap();
        cyc(1);
        push("resume_page", 0, 64'd0);
        push("resume_frozen", 2, 64'd1);
        push("resume_hex", 1, exp_hex(0, 0));
        drain();
        cyc(5);
        push("resume_tick", 0, 64'd1);
        drain();
        cyc(1);
        push("resume_hex_p1", 1, exp_hex(1, 1));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
